// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_arbiter
// Description : Shares one single-port synchronous RAM between instruction
//               fetch and data ports; data has priority and a starvation
//               counter guarantees fetch progress.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] c_MAX_WAIT   = 4'(MAX_WAIT);
    localparam logic [1:0] c_OWN_NONE   = 2'd0;
    localparam logic [1:0] c_OWN_IF     = 2'd1;
    localparam logic [1:0] c_OWN_D      = 2'd2;

    logic [3:0] r_wait_cnt;
    logic [1:0] r_rd_owner;
    logic       w_if_gnt;
    logic       w_d_gnt;
    logic       w_fetch_forced;

    // Fetch beats data only once it has been denied MAX_WAIT cycles in a row.
    assign w_fetch_forced = (r_wait_cnt == c_MAX_WAIT);
    assign w_if_gnt = rstn & if_req & (~d_req | w_fetch_forced);
    assign w_d_gnt  = rstn & d_req & ~(if_req & w_fetch_forced);

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign mem_en    = w_if_gnt | w_d_gnt;
    assign mem_we    = w_d_gnt & d_we;
    assign mem_addr  = w_d_gnt ? d_addr  : (w_if_gnt ? if_addr : '0);
    assign mem_wdata = w_d_gnt ? d_wdata : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wait_cnt <= 4'd0;
        end else if (!if_req || w_if_gnt) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt < c_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Remembers which requester owns the read data returning next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_owner <= c_OWN_NONE;
        end else if (w_if_gnt) begin
            r_rd_owner <= c_OWN_IF;
        end else if (w_d_gnt && !d_we) begin
            r_rd_owner <= c_OWN_D;
        end else begin
            r_rd_owner <= c_OWN_NONE;
        end
    end

    assign if_rvalid = (r_rd_owner == c_OWN_IF);
    assign d_rvalid  = (r_rd_owner == c_OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_dmem_arbiter
// Description : Directed self-checking bench for imem_dmem_arbiter with a
//               behavioural single-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

    localparam int c_AW = 10;
    localparam int c_DW = 32;

    logic            clk;
    logic            rstn;
    logic            if_req;
    logic [c_AW-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [c_DW-1:0] if_rdata;
    logic            d_req;
    logic            d_we;
    logic [c_AW-1:0] d_addr;
    logic [c_DW-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [c_DW-1:0] d_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata;
    logic [c_DW-1:0] mem_rdata;

    logic [c_DW-1:0] r_mem [0:(1<<c_AW)-1];
    logic            r_if_pend;
    logic            r_d_pend;

    int n_checks;
    int n_fails;

    imem_dmem_arbiter #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW),
        .MAX_WAIT   (4)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) r_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= r_mem[mem_addr];
        end
    end

    // Requesters must hold req until granted.
    always @(posedge clk) begin
        if (rstn && r_if_pend) assert (if_req) else $error("if_req dropped before if_gnt");
        if (rstn && r_d_pend)  assert (d_req)  else $error("d_req dropped before d_gnt");
        r_if_pend <= rstn && if_req && !if_gnt;
        r_d_pend  <= rstn && d_req && !d_gnt;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        r_if_pend = 1'b0;
        r_d_pend  = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < (1 << c_AW); i++) r_mem[i] <= '0;
        r_mem[0] <= 32'h0000_0013;
        r_mem[1] <= 32'h0010_0093;
        r_mem[2] <= 32'h0020_0113;
        r_mem[5] <= 32'h0000_0055;

        // Reset with both requests asserted.
        rstn    = 1'b0;
        if_req  = 1'b1;
        if_addr = 10'd3;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'd5;
        d_wdata = '0;
        next_cycle();
        next_cycle();
        #1;
        check_val("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        check_val("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        check_val("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check_val("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check_val("rst_rdata", if_rdata | d_rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_val("rel_d_gnt", {31'd0, d_gnt}, 32'd1);
        check_val("rel_if_gnt", {31'd0, if_gnt}, 32'd0);
        check_val("rel_mem_addr", {22'd0, mem_addr}, 32'd5);

        // Data read granted; fetch still pending takes the next slot.
        next_cycle();
        d_req = 1'b0;
        #1;
        check_val("post_rel_if_gnt", {31'd0, if_gnt}, 32'd1);
        check_val("post_rel_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check_val("post_rel_d_rdata", d_rdata, 32'h0000_0055);
        next_cycle();
        if_req = 1'b0;
        #1;
        check_val("post_rel_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check_val("post_rel_if_rdata", if_rdata, 32'd0);

        // Fetch-only stream over addresses 0,1,2.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 10'd0;
        #1;
        check_val("fetch0_gnt", {31'd0, if_gnt}, 32'd1);
        check_val("fetch0_addr", {22'd0, mem_addr}, 32'd0);
        next_cycle();
        if_addr = 10'd1;
        #1;
        check_val("fetch1_gnt", {31'd0, if_gnt}, 32'd1);
        check_val("fetch0_rdata", if_rdata, 32'h0000_0013);
        check_val("fetch0_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        next_cycle();
        if_addr = 10'd2;
        #1;
        check_val("fetch2_gnt", {31'd0, if_gnt}, 32'd1);
        check_val("fetch1_rdata", if_rdata, 32'h0010_0093);
        next_cycle();
        if_req = 1'b0;
        #1;
        check_val("fetch2_rvalid", {31'd0, if_rvalid}, 32'd1);
        check_val("fetch2_rdata", if_rdata, 32'h0020_0113);
        check_val("idle_mem_en", {31'd0, mem_en}, 32'd0);

        // Data write then read-back of 0x40.
        next_cycle();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h040;
        d_wdata = 32'hDEAD_BEEF;
        #1;
        check_val("wr_gnt", {31'd0, d_gnt}, 32'd1);
        check_val("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check_val("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        d_we    = 1'b0;
        d_wdata = '0;
        #1;
        check_val("wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        check_val("rd_gnt", {31'd0, d_gnt}, 32'd1);
        check_val("rd_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        d_req = 1'b0;
        #1;
        check_val("rd_rvalid", {31'd0, d_rvalid}, 32'd1);
        check_val("rd_rdata", d_rdata, 32'hDEAD_BEEF);

        // Contention: four data grants then one fetch grant, repeating.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 10'd3;
        d_req   = 1'b1;
        d_addr  = 10'h040;
        for (int k = 1; k <= 10; k++) begin
            #1;
            check_val($sformatf("cont%0d_if_gnt", k), {31'd0, if_gnt}, (k % 5 == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("cont%0d_d_gnt", k), {31'd0, d_gnt}, (k % 5 == 0) ? 32'd0 : 32'd1);
            next_cycle();
        end
        if_req = 1'b0;
        #1;
        check_val("cont_tail_d_gnt", {31'd0, d_gnt}, 32'd1);
        check_val("cont_tail_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        next_cycle();
        d_req = 1'b0;
        #1;
        check_val("cont_tail_d_rvalid", {31'd0, d_rvalid}, 32'd1);

        // Fetch granted in N, data read granted in N+1.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 10'd1;
        #1;
        check_val("simul_if_gnt", {31'd0, if_gnt}, 32'd1);
        next_cycle();
        if_req = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 10'h040;
        #1;
        check_val("simul_d_gnt", {31'd0, d_gnt}, 32'd1);
        check_val("simul_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check_val("simul_if_rdata", if_rdata, 32'h0010_0093);
        check_val("simul_d_rvalid_early", {31'd0, d_rvalid}, 32'd0);
        next_cycle();
        d_req = 1'b0;
        #1;
        check_val("simul_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check_val("simul_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check_val("simul_if_rvalid_late", {31'd0, if_rvalid}, 32'd0);
        check_val("simul_if_rdata_late", if_rdata, 32'd0);

        // Reset between a fetch grant and its response.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 10'd2;
        #1;
        check_val("midrst_if_gnt", {31'd0, if_gnt}, 32'd1);
        #1;
        rstn   = 1'b0;
        if_req = 1'b0;
        next_cycle();
        check_val("midrst_rvalid_in_rst", {31'd0, if_rvalid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();
        check_val("midrst_rvalid_after", {31'd0, if_rvalid}, 32'd0);
        check_val("midrst_rdata_after", if_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
